radix3_input_commutator: RTL and testbench
==========================================

Name: radix3_input_commutator

Overview:
- Upstream feeder for the radix-3 butterfly stage.
- Accepts one complex sample per valid cycle, in natural order, for frames of N samples.
- Emits three time-aligned lanes (a, b, c) carrying x[k], x[k+L], x[k+2L] for k = 0..L-1, where L = N/3. These are the operand triples the radix-3 stage consumes on its a/b/c inputs.
- Pure reordering and buffering; no arithmetic on sample data.

Parameters:
- N, 6, frame length in complex samples. Must be a multiple of 3 and at least 3.
- W, 32, width of each real/imaginary field.
- L, N/3, derived lane depth. Not user-overridable.
- CW, clog2(N), counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample strobe.
- in_sof  in  1  start-of-frame marker; qualified by in_valid.
- in_re  in  W  input real part.
- in_img  in  W  input imaginary part.
- a_re, a_img  out  W each  lane a = x[k].
- b_re, b_img  out  W each  lane b = x[k+L].
- c_re, c_img  out  W each  lane c = x[k+2L].
- out_valid  out  1  lanes valid this cycle.
- out_idx  out  CW  k of the current output triple.
- frame_err  out  1  one-cycle pulse on a resynchronising in_sof.

Behaviour:
- Reset (rst=1, asynchronous): position counter cnt=0; out_valid=0; frame_err=0; out_idx=0; all lane outputs 0. Buffer RAM contents are not reset and are don't-care.
- An accepted sample is a cycle with in_valid=1. Its index is p = (in_sof ? 0 : cnt). After acceptance, cnt becomes p+1, wrapping from N-1 to 0.
- p < 2L: write the sample to buf[p]. out_valid=0 next cycle.
- p >= 2L: register the outputs for the next cycle:
  - a <= buf[p-2L]
  - b <= buf[p-L]
  - c <= current input sample
  - out_idx <= p-2L
  - out_valid <= 1
- Latency: each triple appears exactly 1 cycle after the sample x[k+2L] is accepted.
- Throughput: one sample in per cycle sustained; back-to-back frames need no idle cycles.
- The next frame's writes to buf[0..2L-1] always land after the reads for the current frame. No read/write hazard exists.
- in_valid=0: cnt holds; out_valid=0 next cycle; lane outputs and out_idx hold their last values.
- No backpressure. The downstream stage must accept every out_valid cycle.
- in_sof with in_valid while cnt != 0: the partial frame is abandoned and no triples are emitted for it. The sample is taken as index 0 of a new frame. frame_err=1 for exactly the next cycle.
- in_sof with in_valid while cnt == 0: normal frame start; no frame_err.
- in_sof without in_valid: ignored.
- Reset mid-frame: the partial frame is discarded. The first sample after reset is index 0.
- Buffer storage: 2L entries of 2W bits, one write port and two read ports. Reads are combinational or registered, provided the 1-cycle output latency holds.

Decomposition:
- Shared package fft_common_pkg:
  - W default 32.
  - Complex sample type {re, img} of W bits each.
  - Function computing L from N.
- Sub-module r3_lane_buffer: 2L-deep dual-read buffer indexed by cnt.
- Top level holds the counter, sof/err logic and output registers.

Test Plan:
- Reset then one frame (N=6) with in_sof on x0, x_n = (0x10+n, 0x20+n):
  - Cycle after x4: a=(0x10,0x20), b=(0x12,0x22), c=(0x14,0x24), out_idx=0, out_valid=1.
  - Cycle after x5: a=(0x11,0x21), b=(0x13,0x23), c=(0x15,0x25), out_idx=1.
  - out_valid=0 on all other cycles.
- Three back-to-back frames, no gaps: exactly 2 valid triples per frame, correct per frame, with no stale data from the previous frame.
- Random in_valid gaps (~50%) within a frame: the same triples as the gap-free case in order; out_valid never high on a cycle following in_valid=0.
- in_sof asserted on the 3rd sample of a frame: frame_err=1 for one cycle; no triple for the aborted frame; the new frame starting at that sample produces correct triples.
- rst asserted asynchronously mid-frame (between clock edges, after x3): outputs go to 0 immediately; a subsequent clean frame produces correct triples.
- Parameter N=12 (L=4): a ramp of 12 samples yields out_idx 0..3 with a=x_k, b=x_{k+4}, c=x_{k+8}, one cycle after x8..x11.

Source files
------------

// File: rtl/fft_common_pkg.sv
// Shared definitions for the FFT datapath blocks.
//   W_DEFAULT  : default width of each real/imaginary field
//   cplx_t     : packed complex sample {re, img}, W_DEFAULT bits per field
//   lane_depth : radix-3 lane depth L = N/3 for a frame of N samples
package fft_common_pkg;

  localparam int W_DEFAULT = 32;

  typedef struct packed {
    logic [W_DEFAULT-1:0] re;
    logic [W_DEFAULT-1:0] img;
  } cplx_t;

  function automatic int lane_depth(input int n);
    return n / 3;
  endfunction

endpackage

// File: rtl/r3_lane_buffer.sv
// Holds the first two thirds (x[0..2L-1]) of a frame so the radix-3 feeder
// can read x[k] and x[k+L] while x[k+2L] is arriving.
//   clk          : rising-edge clock
//   wr_en_i      : write strobe
//   wr_addr_i    : write index (frame position 0..2L-1)
//   wr_data_i    : packed {re, img} sample
//   rd_a_addr_i  : read index for lane a (k)
//   rd_a_data_o  : buf[k], combinational
//   rd_b_addr_i  : read index for lane b (k+L)
//   rd_b_data_o  : buf[k+L], combinational
// Storage is deliberately not reset; contents are only read after being
// written in the same frame.
module r3_lane_buffer
  import fft_common_pkg::*;
#(
  parameter int N  = 6,
  parameter int DW = 64,
  localparam int DEPTH = 2 * lane_depth(N),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_a_addr_i,
  output logic [DW-1:0] rd_a_data_o,
  input  logic [AW-1:0] rd_b_addr_i,
  output logic [DW-1:0] rd_b_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_a_data_o = mem_q[rd_a_addr_i];
  assign rd_b_data_o = mem_q[rd_b_addr_i];

endmodule

// File: rtl/radix3_input_commutator.sv
// Input commutator for the radix-3 butterfly stage. Takes a natural-order
// stream of N complex samples per frame and presents operand triples
// (x[k], x[k+L], x[k+2L]), k = 0..L-1, L = N/3, on lanes a/b/c.
//   clk, rst              : clock, async active-high reset
//   in_valid, in_sof      : sample strobe and start-of-frame marker
//   in_re, in_img         : input sample
//   a_*, b_*, c_*         : output lanes (x[k], x[k+L], x[k+2L])
//   out_valid, out_idx    : triple strobe and its k
//   frame_err             : one-cycle pulse when in_sof cuts a frame short
// Handshake: valid-only, no ready. A sample is taken on every cycle with
// in_valid=1; a triple is presented for exactly the one cycle out_valid=1
// and the consumer must take it then. Lanes and out_idx hold otherwise.
module radix3_input_commutator
  import fft_common_pkg::*;
#(
  parameter int N = 6,
  parameter int W = W_DEFAULT,
  localparam int L  = lane_depth(N),
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [W-1:0]  in_re,
  input  logic [W-1:0]  in_img,
  output logic [W-1:0]  a_re,
  output logic [W-1:0]  a_img,
  output logic [W-1:0]  b_re,
  output logic [W-1:0]  b_img,
  output logic [W-1:0]  c_re,
  output logic [W-1:0]  c_img,
  output logic          out_valid,
  output logic [CW-1:0] out_idx,
  output logic          frame_err
);

  localparam int AW = $clog2(2 * L);
  localparam logic [CW-1:0] L_C    = CW'(L);
  localparam logic [CW-1:0] L2_C   = CW'(2 * L);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  pos;        // index of the sample on the input this cycle
  logic           upper;      // sample belongs to the last third
  logic [CW-1:0]  a_pos, b_pos;
  logic [2*W-1:0] rd_a, rd_b;
  logic           emit_d, err_d;

  logic [2*W-1:0] a_q, b_q, c_q;
  logic [CW-1:0]  idx_q;
  logic           valid_q, err_q;

  // in_sof forces index 0 regardless of where the counter was, which is
  // how a truncated frame is abandoned.
  always_comb begin
    pos    = in_sof ? '0 : cnt_q;
    upper  = (pos >= L2_C);
    a_pos  = pos - L2_C;
    b_pos  = pos - L_C;
    emit_d = in_valid & upper;
    err_d  = in_valid & in_sof & (cnt_q != '0);
    cnt_d  = cnt_q;
    if (in_valid) begin
      cnt_d = (pos == LAST_C) ? '0 : pos + CW'(1);
    end
  end

  // Only the first two thirds are stored; the last third goes straight to
  // lane c. Reads of buf[k], buf[k+L] happen in the same cycle as x[k+2L]
  // arrives, so the next frame's writes can never overtake them.
  r3_lane_buffer #(
    .N  (N),
    .DW (2 * W)
  ) u_buf (
    .clk         (clk),
    .wr_en_i     (in_valid & ~upper),
    .wr_addr_i   (pos[AW-1:0]),
    .wr_data_i   ({in_re, in_img}),
    .rd_a_addr_i (a_pos[AW-1:0]),
    .rd_a_data_o (rd_a),
    .rd_b_addr_i (b_pos[AW-1:0]),
    .rd_b_data_o (rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= emit_d;
      err_q   <= err_d;
      if (emit_d) begin
        a_q   <= rd_a;
        b_q   <= rd_b;
        c_q   <= {in_re, in_img};
        idx_q <= a_pos;
      end
    end
  end

  assign a_re      = a_q[2*W-1:W];
  assign a_img     = a_q[W-1:0];
  assign b_re      = b_q[2*W-1:W];
  assign b_img     = b_q[W-1:0];
  assign c_re      = c_q[2*W-1:W];
  assign c_img     = c_q[W-1:0];
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_radix3_input_commutator.sv
// Bench for radix3_input_commutator: one instance with N=6 (inst 0) and one
// with N=12 (inst 1). The reference model keeps the current frame as a
// queue of samples; once sample x[k+2L] joins, the triple
// (x[k], x[k+L], x[k+2L]) is due on the following cycle.
module tb_radix3_input_commutator;
  import fft_common_pkg::*;

  localparam int W  = W_DEFAULT;
  localparam int EW = 6 * W + 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         v0, s0, v1, s1;
  logic [W-1:0] re0, im0, re1, im1;
  logic [W-1:0] a_re0, a_im0, b_re0, b_im0, c_re0, c_im0;
  logic [W-1:0] a_re1, a_im1, b_re1, b_im1, c_re1, c_im1;
  logic         ov0, fe0, ov1, fe1;
  logic [2:0]   idx0;
  logic [3:0]   idx1;

  radix3_input_commutator #(.N(6), .W(W)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_sof(s0), .in_re(re0), .in_img(im0),
    .a_re(a_re0), .a_img(a_im0), .b_re(b_re0), .b_img(b_im0),
    .c_re(c_re0), .c_img(c_im0), .out_valid(ov0), .out_idx(idx0), .frame_err(fe0)
  );

  radix3_input_commutator #(.N(12), .W(W)) dut12 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_sof(s1), .in_re(re1), .in_img(im1),
    .a_re(a_re1), .a_img(a_im1), .b_re(b_re1), .b_img(b_im1),
    .c_re(c_re1), .c_img(c_im1), .out_valid(ov1), .out_idx(idx1), .frame_err(fe1)
  );

  // model state and scoreboard
  cplx_t          frm0[$], frm1[$];
  logic [EW-1:0]  exp_q0[$], exp_q1[$];
  bit             err_now0, err_now1, ev_now0, ev_now1;
  bit             err_exp0, err_exp1, ev0, ev1;
  int             checks = 0;
  int             failures = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cplx_t rand_x();
    cplx_t x;
    x.re  = $urandom;
    x.img = $urandom;
    return x;
  endfunction

  task automatic model_step(input int inst, input bit sof, input cplx_t x);
    cplx_t         f[$];
    int            n, l, k;
    bit            err, ev;
    logic [EW-1:0] e;
    if (inst == 0) begin f = frm0; n = 6; end
    else begin f = frm1; n = 12; end
    l   = n / 3;
    err = 1'b0;
    ev  = 1'b0;
    if (sof) begin
      err = (f.size() != 0);
      f.delete();
    end
    f.push_back(x);
    k = f.size() - 1 - 2 * l;
    if (k >= 0) begin
      e  = {f[k], f[k+l], f[k+2*l], 8'(k)};
      ev = 1'b1;
      if (inst == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
    if (f.size() == n) f.delete();
    if (inst == 0) begin frm0 = f; err_now0 = err; ev_now0 = ev; end
    else begin frm1 = f; err_now1 = err; ev_now1 = ev; end
  endtask

  // driver tasks: one call = one clock cycle of input
  task automatic send(input int inst, input bit v, input bit sof, input cplx_t x);
    @(negedge clk);
    v0 = 1'b0; s0 = 1'b0; v1 = 1'b0; s1 = 1'b0;
    err_now0 = 1'b0; err_now1 = 1'b0; ev_now0 = 1'b0; ev_now1 = 1'b0;
    if (inst == 0) begin v0 = v; s0 = sof; re0 = x.re; im0 = x.img; end
    else begin v1 = v; s1 = sof; re1 = x.re; im1 = x.img; end
    if (v) model_step(inst, sof, x);
  endtask

  // idle cycles carry random in_sof, which must be ignored without in_valid
  task automatic idle(input int inst, input int cycles);
    repeat (cycles) send(inst, 1'b0, 1'($urandom_range(0, 1)), rand_x());
  endtask

  task automatic send_frame(input int inst, input int n, input bit gaps, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle(inst, int'($urandom_range(0, 1)));
      send(inst, 1'b1, sof_first && (i == 0), rand_x());
    end
  endtask

  // expectations for the cycle after each edge
  always @(posedge clk) begin
    err_exp0 = err_now0;
    err_exp1 = err_now1;
    ev0      = ev_now0;
    ev1      = ev_now1;
  end

  // monitor: compares whatever the DUTs present, mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      check("frame_err6", EW'(fe0), EW'(err_exp0));
      check("out_valid6", EW'(ov0), EW'(ev0));
      if (ov0) begin
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_triple6: got out_valid=1 expected no triple");
        end else begin
          check("triple6", {a_re0, a_im0, b_re0, b_im0, c_re0, c_im0, 8'(idx0)}, exp_q0.pop_front());
        end
      end
      check("frame_err12", EW'(fe1), EW'(err_exp1));
      check("out_valid12", EW'(ov1), EW'(ev1));
      if (ov1) begin
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_triple12: got out_valid=1 expected no triple");
        end else begin
          check("triple12", {a_re1, a_im1, b_re1, b_im1, c_re1, c_im1, 8'(idx1)}, exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    cplx_t x;
    rst = 1'b1;
    v0 = 1'b0; s0 = 1'b0; v1 = 1'b0; s1 = 1'b0;
    re0 = '0; im0 = '0; re1 = '0; im1 = '0;
    err_now0 = 1'b0; err_now1 = 1'b0; ev_now0 = 1'b0; ev_now1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset6", EW'({a_re0, a_im0, b_re0, b_im0, c_re0, c_im0, ov0, fe0, idx0}), '0);
    check("reset12", EW'({a_re1, a_im1, b_re1, b_im1, c_re1, c_im1, ov1, fe1, idx1}), '0);
    rst = 1'b0;

    // ramp frame x_n = (0x10+n, 0x20+n)
    for (int n = 0; n < 6; n++) begin
      x.re  = 32'(16 + n);
      x.img = 32'(32 + n);
      send(0, 1'b1, n == 0, x);
    end
    idle(0, 2);

    // three back-to-back frames
    for (int f = 0; f < 3; f++) send_frame(0, 6, 1'b0, 1'b1);

    // random ~50% gaps inside frames, sof sometimes omitted at a clean start
    for (int f = 0; f < 4; f++) send_frame(0, 6, 1'b1, 1'($urandom_range(0, 1)));
    idle(0, 2);

    // resynchronising sof on the 3rd sample
    send(0, 1'b1, 1'b1, rand_x());
    send(0, 1'b1, 1'b0, rand_x());
    send(0, 1'b1, 1'b1, rand_x());
    for (int i = 0; i < 5; i++) send(0, 1'b1, 1'b0, rand_x());
    // sof at a frame boundary: no error
    send_frame(0, 6, 1'b0, 1'b1);

    // asynchronous reset between edges, after x3 of a frame
    for (int i = 0; i < 4; i++) send(0, 1'b1, i == 0, rand_x());
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset6", EW'({a_re0, a_im0, b_re0, b_im0, c_re0, c_im0, ov0, fe0, idx0}), '0);
    check("async_reset12", EW'({a_re1, a_im1, b_re1, b_im1, c_re1, c_im1, ov1, fe1, idx1}), '0);
    v0 = 1'b0; s0 = 1'b0; v1 = 1'b0; s1 = 1'b0;
    err_now0 = 1'b0; err_now1 = 1'b0; ev_now0 = 1'b0; ev_now1 = 1'b0;
    frm0.delete(); frm1.delete(); exp_q0.delete(); exp_q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // first sample after reset is index 0 even without sof
    send_frame(0, 6, 1'b0, 1'b0);
    idle(0, 3);

    // N=12: ramp, then back-to-back and gapped frames, then an abort
    for (int n = 0; n < 12; n++) begin
      x.re  = 32'(256 + n);
      x.img = 32'(512 + n);
      send(1, 1'b1, n == 0, x);
    end
    send_frame(1, 12, 1'b0, 1'b1);
    send_frame(1, 12, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) send(1, 1'b1, i == 0, rand_x());
    send_frame(1, 12, 1'b1, 1'b1);
    idle(1, 3);

    check("drain6", EW'(exp_q0.size()), '0);
    check("drain12", EW'(exp_q1.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
